// File: rtl/id_exe_pipe_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// id_exe_pipe_stage : elastic ID/EX stage latch with skid entry, flush, freeze
// Revision 1.0
// ---------------------------------------------------------------------------
module id_exe_pipe_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 6,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CNT_W-1:0]    r_bubble_cnt;

  logic w_live;
  logic w_push;
  logic w_pop;

  assign w_live = cpu_en & ~flush & ~rst;

  // With the skid entry, in_ready depends only on registered state.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = w_live & (r_state != ST_FULL);
    end else begin : g_noskid
      assign in_ready = w_live & ((r_state == ST_EMPTY) | out_ready);
    end
  endgenerate

  assign out_valid  = w_live & (r_state != ST_EMPTY);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign out_data   = rst ? '0 : r_main_data;
  assign out_ctrl   = out_valid ? r_main_ctrl : '0;
  assign bubble_cnt = r_bubble_cnt;

  always_comb begin
    occupancy = 2'd0;
    if (!rst) begin
      case (r_state)
        ST_HALF: occupancy = 2'd1;
        ST_FULL: occupancy = 2'd2;
        default: occupancy = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      // Data is left in place; clearing control alone turns entries into NOPs.
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else if (cpu_en) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_state     <= ST_HALF;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end
        end
        ST_HALF: begin
          if (w_push && !w_pop) begin
            if (SKID != 0) begin
              r_state     <= ST_FULL;
              r_skid_data <= in_data;
              r_skid_ctrl <= in_ctrl;
            end
          end else if (w_push && w_pop) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state     <= ST_HALF;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (cpu_en && out_ready && !out_valid && !(&r_bubble_cnt)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_exe_pipe_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_id_exe_pipe_stage : scoreboard bench, SKID=1 and SKID=0/CNT_W=2 instances
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_id_exe_pipe_stage;
  localparam int DW = 64;
  localparam int CW = 6;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cpu_en    = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [CW-1:0] in_ctrl   = '0;

  logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [DW-1:0] a_out_data, b_out_data;
  logic [CW-1:0] a_out_ctrl, b_out_ctrl;
  logic [1:0]    a_occ, b_occ;
  logic [15:0]   a_cnt;
  logic [1:0]    b_cnt;

  ent_t qa[$];
  ent_t qb[$];
  int   ca = 0;
  int   cb = 0;
  bit   mon_en = 1'b0;
  bit   a_push, a_pop, a_bub, b_push, b_pop, b_bub;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_exe_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ), .bubble_cnt(a_cnt)
  );

  id_exe_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .occupancy(b_occ), .bubble_cnt(b_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected behaviour from the entry count of an ideal FIFO of depth 1 or 2.
  task automatic check_dut(input string nm, input bit skid, input int qs, input ent_t front,
                           input logic ir, input logic ov, input logic [DW-1:0] od,
                           input logic [CW-1:0] oc, input logic [1:0] occ,
                           input logic [31:0] cnt, input int ecnt,
                           output bit psh, output bit pp, output bit bub);
    bit live, eir, eov;
    live = !rst && cpu_en && !flush;
    eov  = live && (qs > 0);
    eir  = skid ? (live && qs < 2) : (live && (qs == 0 || out_ready));
    chk({nm, " in_ready"}, 64'(ir), 64'(eir));
    chk({nm, " out_valid"}, 64'(ov), 64'(eov));
    chk({nm, " occupancy"}, 64'(occ), 64'(rst ? 0 : qs));
    chk({nm, " bubble_cnt"}, 64'(cnt), 64'(ecnt));
    if (eov) begin
      chk({nm, " out_data"}, od, front[DW-1:0]);
      chk({nm, " out_ctrl"}, 64'(oc), 64'(front[CW+DW-1:DW]));
    end else begin
      chk({nm, " out_ctrl idle"}, 64'(oc), 64'd0);
    end
    psh = eir && in_valid;
    pp  = eov && out_ready;
    bub = !rst && cpu_en && out_ready && !eov;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      check_dut("A", 1'b1, qa.size(), (qa.size() > 0) ? qa[0] : ent_t'(0),
                a_in_ready, a_out_valid, a_out_data, a_out_ctrl, a_occ, {16'd0, a_cnt}, ca,
                a_push, a_pop, a_bub);
      check_dut("B", 1'b0, qb.size(), (qb.size() > 0) ? qb[0] : ent_t'(0),
                b_in_ready, b_out_valid, b_out_data, b_out_ctrl, b_occ, {30'd0, b_cnt}, cb,
                b_push, b_pop, b_bub);
    end else begin
      a_push = 1'b0; a_pop = 1'b0; a_bub = 1'b0;
      b_push = 1'b0; b_pop = 1'b0; b_bub = 1'b0;
    end
  end

  // Scoreboard update on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      ca <= 0;
      cb <= 0;
    end else if (mon_en) begin
      if (a_bub) ca <= (ca == 65535) ? ca : ca + 1;
      if (b_bub) cb <= (cb == 3) ? cb : cb + 1;
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (a_pop) void'(qa.pop_front());
        if (a_push) qa.push_back({in_ctrl, in_data});
        if (b_pop) void'(qb.pop_front());
        if (b_push) qb.push_back({in_ctrl, in_data});
      end
    end
  end

  task automatic drive(input bit en, input bit fl, input bit iv, input bit ordy,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
    cpu_en    = en;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
    in_ctrl   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    rst = 1'b0;
    // Idle with out_ready high: counters walk 1,2,3,3,3 on the 2-bit instance.
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 64'h0, 6'h0);
    chk("A out_data after reset", a_out_data, 64'h0);
    chk("B out_data after reset", b_out_data, 64'h0);
    rst = 1'b1;
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    rst = 1'b0;

    // Stream three entries
    drive(1, 0, 1, 1, 64'h11, 6'h01);
    drive(1, 0, 1, 1, 64'h22, 6'h02);
    drive(1, 0, 1, 1, 64'h33, 6'h03);
    drive(1, 0, 0, 1, 64'h0, 6'h0);

    // Backpressure into the skid entry, then release
    drive(1, 0, 1, 0, 64'hA1, 6'h0A);
    drive(1, 0, 1, 0, 64'hB2, 6'h0B);
    drive(1, 0, 0, 0, 64'h0, 6'h0);
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    drive(1, 0, 0, 1, 64'h0, 6'h0);

    // Flush while full, with a competing push and a ready consumer
    drive(1, 0, 1, 0, 64'hC3, 6'h2D);
    drive(1, 0, 1, 0, 64'hD4, 6'h15);
    drive(1, 1, 1, 1, 64'hE5, 6'h3F);
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    drive(1, 0, 1, 1, 64'hF6, 6'h07);
    drive(1, 0, 0, 1, 64'h0, 6'h0);

    // Freeze while half full
    drive(1, 0, 1, 0, 64'h77, 6'h11);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 64'h88, 6'h12);
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    drive(1, 0, 0, 1, 64'h0, 6'h0);

    // Combinational ready on the single-register instance
    drive(1, 0, 1, 0, 64'h91, 6'h21);
    drive(1, 0, 1, 0, 64'h92, 6'h22);
    drive(1, 0, 1, 1, 64'h93, 6'h23);
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    drive(1, 0, 0, 1, 64'h0, 6'h0);
    drive(1, 0, 0, 1, 64'h0, 6'h0);

    // Randomised traffic, including occasional reset mid-operation
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            {$urandom, $urandom}, 6'($urandom));
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 64'h0, 6'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/id_exe_pipe_stage.md
# id_exe_pipe_stage

Parametrised, elastic pipeline register for the decode-to-execute boundary, and the general stage latch for the rest of the pipeline. It carries a data payload (ALU operands) and a control payload (ALU option plus write-enable flags) with a valid/ready handshake. A one-entry skid buffer keeps `in_ready` registered. Flush inserts a bubble, global `cpu_en` freezes the stage, and a saturating counter records output bubble cycles.

## Interface
- `DATA_W`, 64: data payload width (two 32-bit operands).
- `CTRL_W`, 6: control payload width; all-zero control means bubble/NOP.
- `SKID`, 1: 1 = two-entry skid stage with registered `in_ready`; 0 = single register, `in_ready` combinational from `out_ready`.
- `CNT_W`, 16: bubble counter width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_en`  in  1  global enable; 0 freezes the stage.
- `flush`  in  1  kill all held entries, insert bubble.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage accepts an entry this cycle.
- `in_data`  in  DATA_W  upstream data payload.
- `in_ctrl`  in  CTRL_W  upstream control payload.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  output data payload.
- `out_ctrl`  out  CTRL_W  output control payload; forced 0 when `out_valid`=0.
- `occupancy`  out  2  entries held (0..2).
- `bubble_cnt`  out  CNT_W  saturating count of bubble cycles.

## Operation
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`. Both require `cpu_en`=1, `flush`=0, `rst`=0.
- States: EMPTY (0 entries), HALF (main register valid), FULL (main plus skid valid; SKID=1 only).
- EMPTY: push -> HALF, main <= input.
- HALF:
  - push & !pop -> FULL, skid <= input.
  - push & pop -> HALF, main <= input.
  - pop only -> EMPTY.
- FULL: pop -> HALF, main <= skid. Push is impossible here.
- Ordering is strict FIFO. The skid entry never overtakes the main entry.
- `in_ready`:
  - SKID=1: `cpu_en & !flush & !rst & state!=FULL`. Depends only on registered state, not on `out_ready`.
  - SKID=0: `cpu_en & !flush & !rst & (state==EMPTY | out_ready)`.
- `out_valid` = `cpu_en & !flush & state!=EMPTY`. `out_data` shows the main register and holds its last value when invalid. `out_ctrl` = main control when `out_valid`, else 0.
- `cpu_en`=0: state, payloads and counter hold, and no transfer occurs.
- `flush`=1 (acts regardless of `cpu_en`):
  - Next state is EMPTY.
  - Same-cycle input is discarded.
  - The current output is not consumed, even if `out_ready`=1.
  - Stored control is cleared to 0; stored data is unchanged.
- `bubble_cnt`:
  - Increments when `cpu_en & out_ready & !out_valid`, flush cycles included.
  - Saturates at all-ones and never wraps.
  - Cleared only by `rst`.
- Priority: `rst` > `flush` > `cpu_en` gating > handshake.

## Timing
- Reset: state EMPTY, all payload registers 0, `bubble_cnt` 0.
  - Outputs during and after reset: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=0 while `rst`=1; with `cpu_en`=1 it reads 1 in the first cycle after `rst` falls.
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput: one entry per cycle with `out_ready` held high, for both SKID values.
- SKID=1, `out_ready` falls while streaming: one more entry lands in skid, and `in_ready` drops the following cycle. When `out_ready` returns: one pop makes room, and `in_ready` rises one cycle later.
- Reset mid-operation discards both entries. Nothing partial is emitted.
- Flush followed immediately by push: the entry is accepted in the cycle after flush deasserts.

## Test plan
- Stream: SKID=1; push 0x11,0x22,0x33 with `out_ready`=1. Outputs appear one cycle later, consecutively, in order; `occupancy` stays 1.
- Backpressure: SKID=1, HALF holding 0xA1; drop `out_ready` and push 0xB2. State goes FULL and `in_ready`=0 next cycle. Raise `out_ready`: 0xA1 then 0xB2 emerge; `in_ready`=1 one cycle after the first pop.
- Flush: FULL with `out_ctrl`=0x2D; assert `flush` one cycle with `in_valid`=1 and `out_ready`=1.
  - During the flush cycle: `out_valid`=0 and `out_ctrl`=0.
  - After the flush cycle: `occupancy`=0, and the input is not stored.
- Freeze: HALF; hold `cpu_en`=0 for 3 cycles with `in_valid`/`out_ready`=1. `in_ready`=0, `out_valid`=0, state unchanged, `bubble_cnt` unchanged. Resume: the held entry pops first.
- Counter: CNT_W=2; 5 cycles EMPTY with `out_ready`=1. `bubble_cnt` reads 1, 2, 3, 3, 3. Assert `rst`: reads 0.
- SKID=0, HALF, `out_ready`=0: `in_ready`=0 in the same cycle. With `out_ready`=1 and a simultaneous push/pop, the new entry replaces the old in one edge.
